// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq -- registered, width-generic ALU with valid/ready handshakes.
//
// Sits between register read and writeback. Single-cycle ops (AND, OR, NOR,
// NAND, ADD, SUB, SLT) are accepted and registered on one edge, so the result
// is visible in the next cycle at a throughput of one op per cycle. The
// optional unsigned multiplier (MULU) is a shift-add loop that holds off
// upstream through in_ready until its result has been consumed.
//
// Build option:
//   ALU_SEQ_MUL_EN  defined   -> MULU (opcode 1000) is implemented.
//                   undefined -> no multiplier hardware; 1000 is illegal.
//
// Parameters:
//   WIDTH        operand/result width, 4..64.
//   CNT_W        multiply iteration counter width, $clog2(WIDTH)+1; derived
//                internally (only exists when the multiplier is built).
//
// Ports:
//   clk_i        clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     operation request
//   in_ready     block can accept a request this cycle
//   src1, src2   operands A and B
//   ALU_control  opcode; bit3 inverts A, bit2 inverts B
//   out_valid    result registers hold a valid result
//   out_ready    consumer takes the result this cycle
//   result       result, or low half of the product
//   result_hi    high half of the product; 0 for every other op
//   zero         result == 0 (low half only)
//   cout         carry out of the MSB (ADD/SUB only)
//   overflow     signed overflow (ADD/SUB) or product wider than WIDTH (MULU)
// -----------------------------------------------------------------------------
`default_nettype none

module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [3:0]       ALU_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             cout,
  output logic             overflow
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_NAND = 4'b1101;
`ifdef ALU_SEQ_MUL_EN
  localparam logic [3:0] OP_MULU = 4'b1000;
`endif

  // ---------------------------------------------------------------------------
  // Single-cycle datapath
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] a_eff;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             slt;
  logic [WIDTH-1:0] sc_result;
  logic             sc_cout;
  logic             sc_ovf;

  // NOR and NAND are AND/OR with both inputs inverted (De Morgan), so the
  // invert bits of the opcode are applied directly to the operands.
  assign a_eff = ALU_control[3] ? ~src1 : src1;
  assign b_eff = ALU_control[2] ? ~src2 : src2;

  // SUB = A + ~B + 1: the B-invert bit doubles as the carry-in.
  assign sum = {1'b0, src1} + {1'b0, b_eff} + {{WIDTH{1'b0}}, ALU_control[2]};

  // A true signed compare, not the sign of (src1 - src2), so SLT stays correct
  // when the subtraction overflows.
  assign slt = $signed(src1) < $signed(src2);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // opcode path can leave a value unassigned and infer a latch.
    sc_result = '0;
    sc_cout   = 1'b0;
    sc_ovf    = 1'b0;
    case (ALU_control)
      OP_AND, OP_NOR: sc_result = a_eff & b_eff;
      OP_OR, OP_NAND: sc_result = a_eff | b_eff;
      OP_ADD, OP_SUB: begin
        sc_result = sum[WIDTH-1:0];
        sc_cout   = sum[WIDTH];
        // Overflow when both addends share a sign the result does not.
        sc_ovf    = (src1[WIDTH-1] == b_eff[WIDTH-1]) &&
                    (sum[WIDTH-1] != src1[WIDTH-1]);
      end
      OP_SLT: sc_result = {{(WIDTH-1){1'b0}}, slt};
      default: ;  // illegal opcodes: result 0, flags 0
    endcase
  end

  logic accept;
  logic sc_accept;

  assign accept = in_valid && in_ready;

`ifdef ALU_SEQ_MUL_EN
  // ---------------------------------------------------------------------------
  // Multiplier FSM and shift-add datapath
  // ---------------------------------------------------------------------------
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } state_e;

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] mcand_q;   // multiplicand
  logic [WIDTH-1:0] acc_hi_q;  // running high half of the product
  logic [WIDTH-1:0] acc_lo_q;  // multiplier, shifted out as product bits shift in
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   step_sum;
  logic             start_mul;
  logic             mul_done;

  assign start_mul = accept && (ALU_control == OP_MULU);
  assign sc_accept = accept && (ALU_control != OP_MULU);
  assign mul_done  = (state_q == S_MUL) && (cnt_q == '0);
  assign in_ready  = (state_q == S_IDLE) && (!out_valid || out_ready);

  // One extra bit keeps the carry of the partial-product add; it becomes the
  // MSB of the high accumulator after the shift.
  assign step_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_mul)     state_d = S_MUL;
      S_MUL:   if (cnt_q == '0)   state_d = S_DONE;
      S_DONE:  if (out_ready)     state_d = S_IDLE;
      default:                    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values and simulation matches the synthesised hardware.
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    // NOTE: the accumulators and counter are reset as well, so a multiply
    // aborted by reset leaves no partial product to leak into a later one.
    if (!rst_n) begin
      mcand_q  <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      cnt_q    <= '0;
    end else if (start_mul) begin
      mcand_q  <= src1;
      acc_lo_q <= src2;
      acc_hi_q <= '0;
      cnt_q    <= CNT_W'(WIDTH);
    end else if ((state_q == S_MUL) && (cnt_q != '0)) begin
      acc_hi_q <= step_sum[WIDTH:1];
      acc_lo_q <= {step_sum[0], acc_lo_q[WIDTH-1:1]};
      cnt_q    <= cnt_q - 1'b1;
    end
  end
`else
  // Without the multiplier the block never leaves IDLE.
  assign sc_accept = accept;
  assign in_ready  = !out_valid || out_ready;
`endif

  // ---------------------------------------------------------------------------
  // Output registers. Nothing is loaded while out_valid && !out_ready (no
  // accept is possible then), which freezes all outputs for the consumer.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      result_hi <= '0;
      zero      <= 1'b0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else if (sc_accept) begin
      // Also covers the back-to-back case: a result consumed on this edge is
      // replaced by the new one and out_valid stays high.
      result    <= sc_result;
      result_hi <= '0;
      zero      <= (sc_result == '0);
      cout      <= sc_cout;
      overflow  <= sc_ovf;
      out_valid <= 1'b1;
`ifdef ALU_SEQ_MUL_EN
    end else if (mul_done) begin
      result    <= acc_lo_q;
      result_hi <= acc_hi_q;
      zero      <= (acc_lo_q == '0);
      cout      <= 1'b0;
      overflow  <= (acc_hi_q != '0);
      out_valid <= 1'b1;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq -- self-checking bench for alu_seq (WIDTH = 32).
//
// Directed vectors stream back-to-back through the ALU, hand-written
// sequences cover the multiply hold and a reset in mid-multiply, and a
// randomized phase compares against an arithmetic reference model. MULU
// expectations follow ALU_SEQ_MUL_EN, as the bench is compiled with the RTL.
// -----------------------------------------------------------------------------
module tb_alu_seq;

  localparam int W = 32;
`ifdef ALU_SEQ_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif
  localparam longint MAX_S = (longint'(1) <<< (W - 1)) - 1;
  localparam longint MIN_S = -(longint'(1) <<< (W - 1));

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_NAND = 4'b1101;
  localparam logic [3:0] OP_MULU = 4'b1000;

  logic         clk_i       = 1'b0;
  logic         rst_n       = 1'b0;
  logic         in_valid    = 1'b0;
  logic         out_ready   = 1'b0;
  logic [W-1:0] src1        = '0;
  logic [W-1:0] src2        = '0;
  logic [3:0]   ALU_control = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic         zero;
  logic         cout;
  logic         overflow;

  int n_checks = 0;
  int n_errors = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk_i       (clk_i),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .src1        (src1),
    .src2        (src2),
    .ALU_control (ALU_control),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .result_hi   (result_hi),
    .zero        (zero),
    .cout        (cout),
    .overflow    (overflow)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         z;
    logic         c;
    logic         v;
  } exp_t;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    exp_t         e;
  } vec_t;

  // Reference model: plain integer arithmetic on 64-bit values.
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t            e;
    longint          sa, sb, sr;
    longint unsigned ua, ub, p;
    e  = '{default: '0};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      OP_AND:  e.res = a & b;
      OP_OR:   e.res = a | b;
      OP_NOR:  e.res = ~(a | b);
      OP_NAND: e.res = ~(a & b);
      OP_ADD: begin
        p     = ua + ub;
        e.res = p[W-1:0];
        e.c   = p[W];
        sr    = sa + sb;
        e.v   = (sr > MAX_S) || (sr < MIN_S);
      end
      OP_SUB: begin
        e.res = a - b;
        e.c   = (ua >= ub);
        sr    = sa - sb;
        e.v   = (sr > MAX_S) || (sr < MIN_S);
      end
      OP_SLT:  e.res = W'(sa < sb);
      OP_MULU: if (MUL_EN) begin
        p     = ua * ub;
        e.res = p[W-1:0];
        e.hi  = p[2*W-1:W];
        e.v   = (e.hi != 0);
      end
      default: ;
    endcase
    e.z = (e.res == 0);
    return e;
  endfunction

  function automatic vec_t mkv(input logic [3:0] op, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic [W-1:0] res,
                               input logic z, input logic c, input logic v);
    vec_t t;
    t.op = op; t.a = a; t.b = b;
    t.e  = '{res: res, hi: '0, z: z, c: c, v: v};
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input string name, input exp_t e);
    check({name, " out_valid"}, out_valid, 1'b1);
    check({name, " result"},    result,    e.res);
    check({name, " result_hi"}, result_hi, e.hi);
    check({name, " zero"},      zero,      e.z);
    check({name, " cout"},      cout,      e.c);
    check({name, " overflow"},  overflow,  e.v);
  endtask

  // One complete transaction: accept, bounded wait for the result, optional
  // hold with out_ready low, then consume.
  task automatic run_op(input string name, input logic [3:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold);
    exp_t e;
    bit   is_mul;
    bit   ready_seen;
    int   lat;
    e      = model(op, a, b);
    is_mul = MUL_EN && (op == OP_MULU);
    @(negedge clk_i);
    out_ready = (hold == 0);
    check({name, " in_ready idle"}, in_ready, 1'b1);
    src1 = a; src2 = b; ALU_control = op; in_valid = 1'b1;
    @(posedge clk_i); #1;
    // During a multiply keep presenting junk: it must be ignored.
    if (is_mul) begin
      src1 = $urandom; src2 = $urandom; ALU_control = 4'($urandom);
    end else begin
      in_valid = 1'b0;
    end
    lat = 0;
    ready_seen = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) ready_seen = 1'b1;
      @(posedge clk_i); #1;
      lat++;
    end
    in_valid = 1'b0;
    check({name, " edges to out_valid"}, lat, is_mul ? W + 1 : 0);
    if (is_mul) check({name, " in_ready during MUL"}, ready_seen, 1'b0);
    check_out(name, e);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk_i); #1;
      check_out({name, " held"}, e);
      check({name, " in_ready held"}, in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk_i); #1;
    check({name, " out_valid consumed"}, out_valid, 1'b0);
  endtask

  vec_t vecs[13];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit stale;

    vecs[0]  = mkv(OP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 0, 1);
    vecs[1]  = mkv(OP_SUB,  32'h00000005, 32'h00000005, 32'h00000000, 1, 1, 0);
    vecs[2]  = mkv(OP_SUB,  32'h00000003, 32'h00000005, 32'hFFFFFFFE, 0, 0, 0);
    vecs[3]  = mkv(OP_SLT,  32'h80000000, 32'h7FFFFFFF, 32'h00000001, 0, 0, 0);
    vecs[4]  = mkv(OP_SLT,  32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1, 0, 0);
    vecs[5]  = mkv(OP_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 0, 0);
    vecs[6]  = mkv(OP_OR,   32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 0, 0, 0);
    vecs[7]  = mkv(OP_NOR,  32'h0F0F0F0F, 32'hF0F0F0F0, 32'h00000000, 1, 0, 0);
    vecs[8]  = mkv(OP_NAND, 32'hFFFFFFFF, 32'h12345678, 32'hEDCBA987, 0, 0, 0);
    vecs[9]  = mkv(OP_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 1, 0);
    vecs[10] = mkv(OP_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 0, 1, 1);
    vecs[11] = mkv(4'b0011, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1, 0, 0);
    vecs[12] = mkv(4'b1111, 32'hABCD0000, 32'h00001234, 32'h00000000, 1, 0, 0);

    // Reset state.
    repeat (3) @(posedge clk_i);
    #1;
    check("reset out_valid", out_valid, 1'b0);
    check("reset result",    result,    '0);
    check("reset result_hi", result_hi, '0);
    check("reset flags",     {zero, cout, overflow}, 3'b000);
    check("reset in_ready",  in_ready,  1'b1);
    @(negedge clk_i);
    rst_n = 1'b1;

    // Directed vectors, streamed back-to-back: one result per cycle.
    out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk_i);
      check($sformatf("vec%0d in_ready", i), in_ready, 1'b1);
      src1 = vecs[i].a; src2 = vecs[i].b; ALU_control = vecs[i].op;
      in_valid = 1'b1;
      @(posedge clk_i); #1;
      check_out($sformatf("vec%0d", i), vecs[i].e);
    end
    @(negedge clk_i);
    in_valid = 1'b0;
    @(posedge clk_i); #1;
    check("stream drained", out_valid, 1'b0);

    // Multiply with a 3-cycle consumer stall (single-cycle illegal op when
    // the multiplier is not built).
    run_op("mulu_ffff_x2", OP_MULU, 32'hFFFFFFFF, 32'h00000002, 3);
    run_op("mulu_zero",    OP_MULU, 32'h00000000, 32'h12345678, 0);

    // Reset in the middle of a multiply: leave a nonzero result behind first.
    run_op("pre_reset_add", OP_ADD, 32'h10, 32'h20, 0);
    @(negedge clk_i);
    src1 = 32'hFFFFFFFF; src2 = 32'hFFFFFFFF; ALU_control = OP_MULU;
    in_valid = 1'b1;
    @(posedge clk_i); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk_i);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid reset out_valid", out_valid, 1'b0);
    check("mid reset result",    result,    '0);
    check("mid reset result_hi", result_hi, '0);
    check("mid reset flags",     {zero, cout, overflow}, 3'b000);
    @(negedge clk_i);
    rst_n = 1'b1;
    #1;
    check("after reset in_ready", in_ready, 1'b1);
    stale = 1'b0;
    repeat (40) begin
      @(posedge clk_i); #1;
      if (out_valid) stale = 1'b1;
    end
    check("no stale out_valid after reset", stale, 1'b0);

    // Randomized transactions against the reference model.
    for (int n = 0; n < 150; n++) begin
      logic [3:0]   op;
      logic [W-1:0] a, b;
      logic [W-1:0] edge_vals [4];
      edge_vals[0] = '0;           edge_vals[1] = '1;
      edge_vals[2] = 32'h80000000; edge_vals[3] = 32'h7FFFFFFF;
      case ($urandom_range(0, 8))
        0: op = OP_AND;   1: op = OP_OR;   2: op = OP_ADD;
        3: op = OP_SUB;   4: op = OP_SLT;  5: op = OP_NOR;
        6: op = OP_NAND;  7: op = OP_MULU;
        default: op = 4'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0: begin a = edge_vals[$urandom_range(0, 3)]; b = edge_vals[$urandom_range(0, 3)]; end
        1: begin a = W'($urandom_range(0, 255)); b = W'($urandom_range(0, 255)); end
        default: begin a = $urandom; b = $urandom; end
      endcase
      run_op($sformatf("rnd%0d op%b", n, op), op, a, b, $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the 32-bit combinational ALU.
- Width-generic datapath with valid/ready handshakes on input and output.
- Single-cycle logic and add/sub/slt ops, plus a multi-cycle unsigned shift-add multiplier driven by a small FSM.
- Sits between the register-read stage and writeback; stalls upstream via in_ready while a multiply is in flight.

Parameters:
- WIDTH, 32, operand/result width in bits (legal range 4..64).
- CNT_W, $clog2(WIDTH)+1, multiply iteration counter width; derived, not to be overridden.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept a request this cycle.
- src1  input  WIDTH  operand A.
- src2  input  WIDTH  operand B.
- ALU_control  input  4  opcode.
- out_valid  output  1  result registers hold a valid result.
- out_ready  input  1  consumer takes the result this cycle.
- result  output  WIDTH  result, or low half of product.
- result_hi  output  WIDTH  high half of product; 0 for non-MUL ops.
- zero  output  1  result == 0 (low half only).
- cout  output  1  carry out of MSB.
- overflow  output  1  signed overflow (ADD/SUB), or product exceeds WIDTH (MUL).

Behaviour:
- Reset is asynchronous and applies immediately on rst_n low: FSM to IDLE; result, result_hi, zero, cout, overflow and out_valid all 0; multiply accumulators and counter cleared.
- A reset during MUL aborts the operation; no result is produced.
- in_ready = (state==IDLE) && (!out_valid || out_ready). A request is accepted on a rising edge when in_valid && in_ready.
- Opcodes (bit3 = A-invert, bit2 = B-invert):
  - 0000 AND; 0001 OR; 0010 ADD; 0110 SUB; 0111 SLT; 1100 NOR; 1101 NAND; 1000 MULU.
  - Any other code is illegal: result 0, zero 1, other flags 0, single-cycle latency.
- Single-cycle ops: registered on the accepting edge; out_valid=1 on the following cycle (latency 1).
- ADD/SUB: cout is the carry out of bit WIDTH-1. For SUB, cout=1 means no borrow (src1 >= src2 unsigned). overflow is the signed overflow of the WIDTH-bit result.
- SLT: result = {0..0, signed(src1) < signed(src2)}, correct even when src1-src2 overflows; cout=0, overflow=0.
- Logic ops: cout=0, overflow=0. result_hi=0 for every non-MUL op.
- FSM states IDLE, MUL, DONE:
  - IDLE -> MUL on acceptance of MULU; operands latched.
  - MUL runs WIDTH iterations, one per cycle: if multiplier LSB is 1, add multiplicand into the high accumulator; then shift right. Counter counts down from WIDTH.
  - MUL -> DONE when the counter reaches 0; result/result_hi/flags registered and out_valid=1.
  - DONE -> IDLE when out_ready=1.
  - Single-cycle ops never leave IDLE.
  - MUL latency: out_valid rises exactly WIDTH+1 edges after the accepting edge.
  - MULU flags: overflow = (result_hi != 0); cout=0; zero from the low half only.
- Output hold: while out_valid && !out_ready, all outputs are frozen and in_ready=0.
- out_valid falls on the edge where out_ready=1, unless a new single-cycle op is accepted on that same edge, in which case out_valid stays 1 with the new result (back-to-back throughput of 1 op/cycle).
- Inputs are ignored whenever in_ready=0, including during MUL.

Optional Feature:
- Macro ALU_SEQ_MUL_EN.
- Defined: MULU is implemented as above.
- Undefined: no multiplier, accumulator or counter logic is built; the FSM reduces to IDLE only; opcode 1000 is treated as illegal (single-cycle, result 0, zero 1, result_hi 0).

Test Plan:
- WIDTH=32, ADD 0x7FFFFFFF + 0x00000001 -> result 0x80000000, overflow 1, cout 0, zero 0, out_valid one cycle after accept.
- SUB 0x00000005 - 0x00000005 -> result 0, zero 1, cout 1, overflow 0; then SUB 0x00000003 - 0x00000005 -> 0xFFFFFFFE, cout 0.
- SLT src1=0x80000000, src2=0x7FFFFFFF -> result 1 (overflowing subtract); then swap operands -> 0.
- MULU 0xFFFFFFFF * 0x00000002 -> result 0xFFFFFFFE, result_hi 0x00000001, overflow 1. in_ready=0 for the whole 32-cycle MUL phase; out_valid at accept+33; with out_ready held low 3 cycles, outputs stable and in_ready stays 0.
- Back-to-back stream: AND, OR, NOR, NAND with out_ready=1 on consecutive cycles -> one result per cycle, no bubbles. Assert rst_n low mid-MULU -> outputs 0 immediately, in_ready=1 after release, no stale out_valid.
- WIDTH=8 build: MULU 0x0F * 0x11 -> result 0xFF, result_hi 0x00, overflow 0, out_valid at accept+9. With ALU_SEQ_MUL_EN undefined, opcode 1000 -> result 0, zero 1 after 1 cycle.
